// File: rtl/dmem_pkg.sv
// Shared types and encodings for the streaming data-memory element.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] OSEL_NONE = 2'b00;
  localparam logic [1:0] OSEL_V    = 2'b01;
  localparam logic [1:0] OSEL_H    = 2'b10;
  localparam logic [1:0] OSEL_BOTH = 2'b11;

  localparam logic ISEL_V = 1'b0;
  localparam logic ISEL_H = 1'b1;

  function automatic logic osel_has_v(input logic [1:0] osel);
    return (osel == OSEL_V) || (osel == OSEL_BOTH);
  endfunction

  function automatic logic osel_has_h(input logic [1:0] osel);
    return (osel == OSEL_H) || (osel == OSEL_BOTH);
  endfunction

endpackage

// File: rtl/dmem_stream_if.sv
// Vertical/horizontal link bundle between a PE cell (master) and the memory element (slave).
interface dmem_stream_if #(
  parameter int unsigned DATA_W = 32
);
  logic              v_vld_i;
  logic              h_vld_i;
  logic [DATA_W-1:0] v_s_i;
  logic [DATA_W-1:0] h_s_i;
  logic [DATA_W-1:0] v_s_o;
  logic [DATA_W-1:0] h_s_o;
  logic              v_vld_o;
  logic              h_vld_o;

  modport master (
    output v_vld_i, h_vld_i, v_s_i, h_s_i,
    input  v_s_o, h_s_o, v_vld_o, h_vld_o
  );

  modport slave (
    input  v_vld_i, h_vld_i, v_s_i, h_s_i,
    output v_s_o, h_s_o, v_vld_o, h_vld_o
  );
endinterface

// File: rtl/dmem_agu.sv
// One strided address-generation channel: loads base/len, then steps by stride until count hits 0.
module dmem_agu #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_len,
  input  logic [ADDR_W-1:0] i_stride,
  input  logic              i_load,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_active
);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
      r_cnt  <= i_len;
    end else if (i_step && (r_cnt != '0)) begin
      // Address wraps modulo depth through natural truncation.
      r_addr <= r_addr + i_stride;
      r_cnt  <= r_cnt - (ADDR_W + 1)'(1);
    end
  end

  assign o_addr   = r_addr;
  assign o_active = (r_cnt != '0);

endmodule

// File: rtl/dmem_stream.sv
// Streaming data memory for the spiral PE array: strided write from one link, registered
// strided read onto either/both links, with busy/done status.
module dmem_stream
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic              cfg_isel,
  input  logic [1:0]        cfg_osel,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W:0]   cfg_w_len,
  input  logic [ADDR_W-1:0] cfg_w_stride,
  input  logic [ADDR_W-1:0] cfg_r_base,
  input  logic [ADDR_W:0]   cfg_r_len,
  input  logic [ADDR_W-1:0] cfg_r_stride,
  input  logic              start,
  dmem_stream_if.slave      lnk,
  output logic              busy,
  output logic              done
);

  state_e r_state, w_state_next;

  logic              r_isel;
  logic [1:0]        r_osel;
  logic [ADDR_W-1:0] r_w_base, r_w_stride, r_r_base, r_r_stride;
  logic [ADDR_W:0]   r_w_len, r_r_len;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;
  logic              r_rd_vld;

  logic              w_idle, w_run, w_cfg_ld, w_launch;
  logic [ADDR_W-1:0] w_ld_w_base, w_ld_w_stride, w_ld_r_base, w_ld_r_stride;
  logic [ADDR_W:0]   w_ld_w_len, w_ld_r_len;
  logic [ADDR_W-1:0] w_w_addr, w_r_addr;
  logic              w_w_active, w_r_active;
  logic              w_sel_vld, w_wr, w_rd;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_v_vld, w_h_vld;

  assign w_idle   = (r_state == IDLE);
  assign w_run    = (r_state == RUN);
  assign w_cfg_ld = cfg_we && w_idle;
  assign w_launch = start && w_idle;

  // A config written in the launch cycle must reach the channels on that same edge.
  assign w_ld_w_base   = cfg_we ? cfg_w_base   : r_w_base;
  assign w_ld_w_len    = cfg_we ? cfg_w_len    : r_w_len;
  assign w_ld_w_stride = cfg_we ? cfg_w_stride : r_w_stride;
  assign w_ld_r_base   = cfg_we ? cfg_r_base   : r_r_base;
  assign w_ld_r_len    = cfg_we ? cfg_r_len    : r_r_len;
  assign w_ld_r_stride = cfg_we ? cfg_r_stride : r_r_stride;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_isel     <= ISEL_V;
      r_osel     <= OSEL_NONE;
      r_w_base   <= '0;
      r_w_len    <= '0;
      r_w_stride <= '0;
      r_r_base   <= '0;
      r_r_len    <= '0;
      r_r_stride <= '0;
    end else if (w_cfg_ld) begin
      r_isel     <= cfg_isel;
      r_osel     <= cfg_osel;
      r_w_base   <= cfg_w_base;
      r_w_len    <= cfg_w_len;
      r_w_stride <= cfg_w_stride;
      r_r_base   <= cfg_r_base;
      r_r_len    <= cfg_r_len;
      r_r_stride <= cfg_r_stride;
    end
  end

  dmem_agu #(
    .ADDR_W (ADDR_W)
  ) u_agu_w (
    .clk      (clk),
    .rst      (rst),
    .i_base   (w_ld_w_base),
    .i_len    (w_ld_w_len),
    .i_stride (w_ld_w_stride),
    .i_load   (w_launch),
    .i_step   (w_wr),
    .o_addr   (w_w_addr),
    .o_active (w_w_active)
  );

  dmem_agu #(
    .ADDR_W (ADDR_W)
  ) u_agu_r (
    .clk      (clk),
    .rst      (rst),
    .i_base   (w_ld_r_base),
    .i_len    (w_ld_r_len),
    .i_stride (w_ld_r_stride),
    .i_load   (w_launch),
    .i_step   (w_rd),
    .o_addr   (w_r_addr),
    .o_active (w_r_active)
  );

  assign w_sel_vld  = (r_isel == ISEL_H) ? lnk.h_vld_i : lnk.v_vld_i;
  assign w_sel_data = (r_isel == ISEL_H) ? lnk.h_s_i   : lnk.v_s_i;
  assign w_wr       = w_run && w_w_active && w_sel_vld;
  assign w_rd       = w_run && w_r_active;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_w_addr] <= w_sel_data;
    end
  end

  // Read samples the array before this edge's write lands, giving read-first on collisions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_vld <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rd_vld <= w_rd;
      if (w_rd) begin
        r_rdata <= r_mem[w_r_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (!w_w_active && !w_r_active && !r_rd_vld) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != IDLE);
    done        = (r_state == DONE);
    w_v_vld     = r_rd_vld && osel_has_v(r_osel);
    w_h_vld     = r_rd_vld && osel_has_h(r_osel);
    lnk.v_vld_o = w_v_vld;
    lnk.h_vld_o = w_h_vld;
    lnk.v_s_o   = w_v_vld ? r_rdata : '0;
    lnk.h_s_o   = w_h_vld ? r_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_stream.sv
// Randomised scoreboard bench for dmem_stream with a word-array reference model.
module tb_dmem_stream;
  import dmem_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  typedef struct {
    logic          isel;
    logic [1:0]    osel;
    logic [AW-1:0] wb;
    logic [AW:0]   wl;
    logic [AW-1:0] ws;
    logic [AW-1:0] rb;
    logic [AW:0]   rl;
    logic [AW-1:0] rs;
  } cfg_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          v;
    logic          h;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0, cfg_isel = 1'b0, start = 1'b0;
  logic [1:0]    cfg_osel = '0;
  logic [AW-1:0] cfg_w_base = '0, cfg_w_stride = '0, cfg_r_base = '0, cfg_r_stride = '0;
  logic [AW:0]   cfg_w_len = '0, cfg_r_len = '0;
  logic          busy, done;

  dmem_stream_if #(.DATA_W(DW)) lnk ();

  dmem_stream #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_isel     (cfg_isel),
    .cfg_osel     (cfg_osel),
    .cfg_w_base   (cfg_w_base),
    .cfg_w_len    (cfg_w_len),
    .cfg_w_stride (cfg_w_stride),
    .cfg_r_base   (cfg_r_base),
    .cfg_r_len    (cfg_r_len),
    .cfg_r_stride (cfg_r_stride),
    .start        (start),
    .lnk          (lnk),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  exp_t          expq[$];
  exp_t          m_e;
  logic [DW-1:0] mem_m [DEPTH];
  cfg_t          cur;
  logic [DW-1:0] wdq[$];
  bit            vpq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every driven output word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (lnk.v_vld_o || lnk.h_vld_o) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual v=%0b h=%0b data=%0h required none",
                   lnk.v_vld_o, lnk.h_vld_o, lnk.v_s_o | lnk.h_s_o);
        end else begin
          m_e = expq.pop_front();
          chk("out_cycle", 64'(cyc), 64'(m_e.cyc));
          chk("v_vld_o", 64'(lnk.v_vld_o), 64'(m_e.v));
          chk("h_vld_o", 64'(lnk.h_vld_o), 64'(m_e.h));
          chk("v_s_o", 64'(lnk.v_s_o), m_e.v ? 64'(m_e.data) : 64'h0);
          chk("h_s_o", 64'(lnk.h_s_o), m_e.h ? 64'(m_e.data) : 64'h0);
        end
      end else begin
        chk("idle_data", {lnk.v_s_o, lnk.h_s_o}, 64'h0);
      end
    end
  end

  task automatic idle_inputs();
    lnk.v_vld_i = 1'b0;
    lnk.h_vld_i = 1'b0;
    lnk.v_s_i   = '0;
    lnk.h_s_i   = '0;
  endtask

  task automatic load_cfg(input cfg_t c, input bit with_start);
    cfg_isel = c.isel;  cfg_osel = c.osel;
    cfg_w_base = c.wb;  cfg_w_len = c.wl;  cfg_w_stride = c.ws;
    cfg_r_base = c.rb;  cfg_r_len = c.rl;  cfg_r_stride = c.rs;
    cfg_we = 1'b1;
    start  = with_start;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    start  = 1'b0;
    cur    = c;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called #1 after the launch edge. Drives wdq/vpq, models each run cycle, checks done timing.
  task automatic run_body(input bit poke, input int abort_at);
    int            k, c0, wi, ri, lastw, t_exp;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] d;
    bit            sv, busy_ok, got;
    c0 = cyc; k = 0; wi = 0; ri = 0; lastw = -1;
    wa = cur.wb; ra = cur.rb; busy_ok = 1'b1; got = 1'b0;
    while (k < 700) begin
      if (k == abort_at) return;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      sv = (k < vpq.size()) ? vpq[k] : 1'b1;
      d  = (wi < wdq.size()) ? wdq[wi] : DW'($urandom);
      if (cur.isel == ISEL_H) begin
        lnk.h_vld_i = sv; lnk.h_s_i = d;
        lnk.v_vld_i = 1'($urandom_range(1, 0)); lnk.v_s_i = DW'($urandom);
      end else begin
        lnk.v_vld_i = sv; lnk.v_s_i = d;
        lnk.h_vld_i = 1'($urandom_range(1, 0)); lnk.h_s_i = DW'($urandom);
      end
      if (ri < int'(cur.rl)) begin
        if (cur.osel != OSEL_NONE)
          expq.push_back('{data: mem_m[ra], v: cur.osel[0], h: cur.osel[1], cyc: c0 + k + 1});
        ra = ra + cur.rs;
        ri++;
      end
      if (wi < int'(cur.wl) && sv) begin
        mem_m[wa] = d;
        wa = wa + cur.ws;
        wi++;
        if (wi == int'(cur.wl)) lastw = k;
      end
      if (poke && k == 1) begin
        cfg_isel = ~cur.isel; cfg_osel = OSEL_BOTH;
        cfg_w_base = AW'($urandom); cfg_w_len = 9'd7; cfg_w_stride = AW'($urandom);
        cfg_r_base = AW'($urandom); cfg_r_len = 9'd5; cfg_r_stride = AW'($urandom);
        cfg_we = 1'b1;
        start  = 1'b1;
      end else if (poke && k == 2) begin
        cfg_we = 1'b0;
        start  = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    idle_inputs();
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_700");
    end else begin
      t_exp = (cur.wl == 0) ? 0 : lastw + 1;
      if (cur.rl != 0 && int'(cur.rl) + 1 > t_exp) t_exp = int'(cur.rl) + 1;
      chk("done_cycle", 64'(k), 64'(t_exp + 1));
      chk("busy_in_run", 64'(busy_ok), 64'd1);
      @(posedge clk); #1;
      chk("back_to_idle", {62'd0, busy, done}, 64'd0);
      chk("queue_drained", 64'(expq.size()), 64'd0);
    end
  endtask

  cfg_t c;

  initial begin
    idle_inputs();
    cur = '{isel: 1'b0, osel: 2'b0, wb: '0, wl: '0, ws: '0, rb: '0, rl: '0, rs: '0};
    #1;
    chk("reset_outs", {58'd0, busy, done, lnk.v_vld_o, lnk.h_vld_o,
                       |lnk.v_s_o, |lnk.h_s_o}, 64'd0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;

    // Fill the whole array so every later read has a known model value.
    c = '{isel: ISEL_V, osel: OSEL_NONE, wb: 8'h00, wl: 9'd256, ws: 8'd1,
          rb: 8'h00, rl: 9'd0, rs: 8'd0};
    wdq.delete(); vpq.delete();
    for (int i = 0; i < 256; i++) wdq.push_back(DW'($urandom));
    load_cfg(c, 1'b1);
    run_body(1'b0, -1);

    // Directed write from vertical link.
    c = '{isel: ISEL_V, osel: OSEL_NONE, wb: 8'h10, wl: 9'd4, ws: 8'd1,
          rb: 8'h00, rl: 9'd0, rs: 8'd0};
    wdq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3}; vpq.delete();
    load_cfg(c, 1'b1);
    run_body(1'b0, -1);

    // Read back on horizontal only; config and start in separate cycles.
    c = '{isel: ISEL_V, osel: OSEL_H, wb: 8'h00, wl: 9'd0, ws: 8'd1,
          rb: 8'h10, rl: 9'd4, rs: 8'd1};
    wdq.delete();
    load_cfg(c, 1'b0);
    do_start();
    run_body(1'b0, -1);

    // Wrapping strided write from horizontal link, then read back both ways.
    c = '{isel: ISEL_H, osel: OSEL_NONE, wb: 8'hFE, wl: 9'd3, ws: 8'd3,
          rb: 8'h00, rl: 9'd0, rs: 8'd0};
    wdq = '{32'hB0, 32'hB1, 32'hB2};
    load_cfg(c, 1'b1);
    run_body(1'b0, -1);
    c = '{isel: ISEL_V, osel: OSEL_BOTH, wb: 8'h00, wl: 9'd0, ws: 8'd0,
          rb: 8'hFE, rl: 9'd3, rs: 8'd3};
    wdq.delete();
    load_cfg(c, 1'b1);
    run_body(1'b0, -1);
    c.rb = 8'h00; c.rl = 9'd6; c.rs = 8'd1; c.osel = OSEL_V;
    load_cfg(c, 1'b1);
    run_body(1'b0, -1);

    // Stalling write with a mid-run config poke, then a start-only rerun of the kept config.
    c = '{isel: ISEL_V, osel: OSEL_NONE, wb: 8'h40, wl: 9'd3, ws: 8'd2,
          rb: 8'h00, rl: 9'd0, rs: 8'd0};
    wdq = '{32'hC0, 32'hC1, 32'hC2}; vpq = '{1, 0, 0, 1, 1};
    load_cfg(c, 1'b1);
    run_body(1'b1, -1);
    wdq = '{32'hD0, 32'hD1, 32'hD2}; vpq = '{0, 1, 1, 0, 1};
    do_start();
    run_body(1'b0, -1);
    vpq.delete();
    c = '{isel: ISEL_V, osel: OSEL_BOTH, wb: 8'h00, wl: 9'd0, ws: 8'd0,
          rb: 8'h40, rl: 9'd3, rs: 8'd2};
    wdq.delete();
    load_cfg(c, 1'b1);
    run_body(1'b0, -1);

    // Same-address read and write in one cycle returns the old word.
    c = '{isel: ISEL_V, osel: OSEL_NONE, wb: 8'h20, wl: 9'd1, ws: 8'd0,
          rb: 8'h00, rl: 9'd0, rs: 8'd0};
    wdq = '{32'h55};
    load_cfg(c, 1'b1);
    run_body(1'b0, -1);
    c = '{isel: ISEL_V, osel: OSEL_V, wb: 8'h20, wl: 9'd1, ws: 8'd0,
          rb: 8'h20, rl: 9'd1, rs: 8'd0};
    wdq = '{32'h77};
    load_cfg(c, 1'b1);
    run_body(1'b0, -1);
    c.wl = 9'd0; c.osel = OSEL_BOTH;
    wdq.delete();
    load_cfg(c, 1'b1);
    run_body(1'b0, -1);

    // Both lengths zero: RUN, DONE, IDLE on consecutive edges.
    c = '{isel: ISEL_V, osel: OSEL_BOTH, wb: 8'h00, wl: 9'd0, ws: 8'd0,
          rb: 8'h00, rl: 9'd0, rs: 8'd0};
    load_cfg(c, 1'b1);
    run_body(1'b0, -1);

    // Asynchronous reset in the middle of a read run.
    c = '{isel: ISEL_V, osel: OSEL_H, wb: 8'h00, wl: 9'd0, ws: 8'd0,
          rb: 8'h10, rl: 9'd8, rs: 8'd1};
    load_cfg(c, 1'b1);
    run_body(1'b0, 3);
    #2;
    rst = 1'b0;
    #1;
    chk("midrun_reset_outs", {58'd0, busy, done, lnk.v_vld_o, lnk.h_vld_o,
                              |lnk.v_s_o, |lnk.h_s_o}, 64'd0);
    expq.delete();
    idle_inputs();
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    cur = '{isel: 1'b0, osel: 2'b0, wb: '0, wl: '0, ws: '0, rb: '0, rl: '0, rs: '0};
    @(posedge clk); #1;
    c = '{isel: ISEL_H, osel: OSEL_BOTH, wb: 8'h80, wl: 9'd5, ws: 8'd1,
          rb: 8'h10, rl: 9'd4, rs: 8'd1};
    wdq.delete();
    load_cfg(c, 1'b1);
    run_body(1'b0, -1);

    // Randomised runs, including overlapping read/write windows and zero strides.
    for (int n = 0; n < 30; n++) begin
      c.isel = 1'($urandom_range(1, 0));
      c.osel = 2'($urandom_range(3, 0));
      c.wb   = AW'($urandom);
      c.wl   = 9'($urandom_range(12, 0));
      c.ws   = ($urandom_range(3, 0) == 0) ? 8'd0 : AW'($urandom_range(5, 1));
      c.rb   = ($urandom_range(1, 0) == 0) ? c.wb : AW'($urandom);
      c.rl   = 9'($urandom_range(12, 0));
      c.rs   = ($urandom_range(3, 0) == 0) ? 8'd0 : AW'($urandom_range(5, 1));
      wdq.delete(); vpq.delete();
      for (int i = 0; i < 40; i++) vpq.push_back($urandom_range(9, 0) < 7);
      if ($urandom_range(1, 0) == 1) begin
        load_cfg(c, 1'b1);
      end else begin
        load_cfg(c, 1'b0);
        do_start();
      end
      run_body(1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_stream.md
Name: dmem_stream

Overview:
- Parametrised streaming data-memory element for the spiral PE array. It sits between compute cells on the vertical and horizontal links.
- Single-port-write / single-port-read RAM driven by two internal address-generation channels (write, read), each with base, length and stride.
- Write data is taken from the vertical or horizontal link. Read data is driven onto vertical, horizontal or both links, with valid flags.
- Adds over the prior memory element: width/depth parameters, autonomous strided addressing, valid handshake, registered read, and done/busy status.

Parameters:
DATA_W, 32, datapath width in bits
ADDR_W, 8, address width; depth = 2**ADDR_W words

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cfg_we  in  1  load configuration fields below; honoured only when busy=0
cfg_isel  in  1  write source: 0=v_s_i, 1=h_s_i
cfg_osel  in  2  read sink: 00=none, 01=vertical, 10=horizontal, 11=both
cfg_w_base  in  ADDR_W  write start address
cfg_w_len  in  ADDR_W+1  write word count (0..2**ADDR_W)
cfg_w_stride  in  ADDR_W  write address increment
cfg_r_base  in  ADDR_W  read start address
cfg_r_len  in  ADDR_W+1  read word count
cfg_r_stride  in  ADDR_W  read address increment
start  in  1  launch both channels; honoured only when busy=0
v_vld_i  in  1  v_s_i valid
h_vld_i  in  1  h_s_i valid
v_s_i  in  DATA_W  vertical input data
h_s_i  in  DATA_W  horizontal input data
v_s_o  out  DATA_W  vertical output data
h_s_o  out  DATA_W  horizontal output data
v_vld_o  out  1  v_s_o valid
h_vld_o  out  1  h_s_o valid
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at completion

Behaviour:
- Reset: state IDLE. All config registers, counters and addresses are 0. v_s_o, h_s_o, v_vld_o, h_vld_o, busy and done are all 0. RAM contents are not reset.
- Config is captured on the clk edge with cfg_we=1 and busy=0. When busy=1, cfg_we is ignored.
- If cfg_we and start are both high in the same idle cycle, the new config is used for that run.
- FSM IDLE -> RUN: on an edge with start=1 in IDLE. At that edge w_addr<=w_base, w_cnt<=w_len, r_addr<=r_base, r_cnt<=r_len. start is ignored while busy.
- Write, per RUN cycle with w_cnt>0 and the selected valid (v_vld_i or h_vld_i per isel) high:
  - mem[w_addr]<=selected data;
  - w_addr<=w_addr+w_stride mod 2**ADDR_W;
  - w_cnt<=w_cnt-1.
  - If the selected valid is low, nothing changes (stall). The non-selected input is ignored.
- Read, per RUN cycle with r_cnt>0:
  - rdata<=mem[r_addr]; r_addr advances by r_stride mod depth; r_cnt decrements.
  - Read is registered with 1-cycle latency: rd_vld is high the following cycle.
  - Read never stalls.
- Same-address read and write in the same cycle: read-first (returns the old word).
- Outputs:
  - v_vld_o = rd_vld & osel[0]; h_vld_o = rd_vld & osel[1].
  - v_s_o/h_s_o equal rdata when their valid is high, else 0.
  - osel=00: reads still advance, but nothing is driven.
- FSM RUN -> DONE: when w_cnt==0, r_cnt==0 and the rd_vld pipeline is empty.
- FSM DONE -> IDLE after one cycle; done=1 only in DONE.
- len=0 on a channel: that channel is complete immediately. With both lengths 0: start edge -> RUN, next edge -> DONE, next edge -> IDLE.
- stride=0 is legal: the same address is repeated. Lengths above the depth are not supported. Wrap is modulo depth.
- rst low mid-run: immediate return to reset state. Partial writes remain in RAM.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - osel encodings OSEL_NONE/V/H/BOTH;
  - isel encodings ISEL_V/ISEL_H.
- One sub-module, dmem_agu: address-generation channel with inputs base, len, stride, load, step and outputs addr, active (cnt!=0). It is instantiated twice.
- RAM array and output muxing live in the top level.

Test Plan:
1. Config isel=V, w_base=0x10, w_len=4, stride=1, r_len=0; start, drive v_vld_i with 0xA0..0xA3 -> mem[0x10..0x13]=A0..A3, done pulses, busy falls.
2. Config w_len=0, r_base=0x10, r_len=4, stride=1, osel=H -> h_vld_o high 4 consecutive cycles starting 2 cycles after start, h_s_o=A0..A3; v_s_o=0 and v_vld_o=0 throughout.
3. Wrap test with ADDR_W=8, w_base=0xFE, stride=3, len=3, h input -> writes hit addresses 0xFE, 0x01, 0x04.
4. Write with v_vld_i pattern 1,0,0,1,1 and len=3 -> exactly 3 writes, done only after the third; asserting cfg_we mid-run leaves config unchanged.
5. Same address: w_base=r_base=0x20, both len=1, mem[0x20]=0x55, write 0x77 -> output 0x55, then mem[0x20]=0x77.
6. Assert rst low mid-run of test 2 -> all outputs and busy become 0 immediately; a following start with new config runs normally.
